// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory bus between the fetch (F)
//   and data (M) ports of the pipeline. Data has priority over fetch. Completed
//   results are held, and done flags stay set, until the whole pipeline
//   advances (no stall from this block and none from ext_stall).
//
//   Optional feature: define ARB_TIMEOUT_EN to enable a bus watchdog. After
//   TIMEOUT_CYCLES busy cycles without mem_ready the transaction is abandoned,
//   the pending port completes with 32'h0 and bus_err latches until reset.
//   Without the macro the arbiter waits indefinitely and bus_err is tied 0.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   inst_req/addr     fetch request (level) and address; inst_rdata result
//   data_req/wen/     data request (level), byte enables (0 = read), address,
//   addr/wdata        write data; data_rdata read result
//   ext_stall         stall from other pipeline sources
//   cpu_stall         global stall to the hazard unit
//   mem_req/wen/      registered bus request, byte enables, address, write data
//   addr/wdata
//   mem_rdata/ready   bus read data and one-cycle completion pulse
//   bus_err           sticky watchdog timeout flag
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        ext_stall,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    IREQ
  } stateT;

  stateT state;
  stateT stateNext;

  logic iDone;
  logic dDone;
  logic iStall;
  logic dStall;
  logic advance;

  logic issueData;
  logic issueInst;
  logic finishOk;
  logic finishTimeout;
  logic timeoutHit;

  assign iStall    = inst_req & ~iDone;
  assign dStall    = data_req & ~dDone;
  assign cpu_stall = iStall | dStall;
  assign advance   = ~cpu_stall & ~ext_stall;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] toCnt;
  logic        busErrQ;

  // Counter is cleared on the issuing edge, so the limit is reached on the
  // TIMEOUT_CYCLES-th edge after mem_req rose.
  assign timeoutHit = (toCnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt   <= '0;
      busErrQ <= 1'b0;
    end else begin
      if (issueData || issueInst) begin
        toCnt <= '0;
      end else if (state != IDLE) begin
        toCnt <= toCnt + 32'd1;
      end
      if (finishTimeout) begin
        busErrQ <= 1'b1;
      end
    end
  end

  assign bus_err = busErrQ;
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext     = state;
    issueData     = 1'b0;
    issueInst     = 1'b0;
    finishOk      = 1'b0;
    finishTimeout = 1'b0;
    case (state)
      IDLE: begin
        // Done flags are the registered ones, so a port that just completed
        // cannot be re-issued before the pipeline advances.
        if (dStall) begin
          issueData = 1'b1;
          stateNext = DREQ;
        end else if (iStall) begin
          issueInst = 1'b1;
          stateNext = IREQ;
        end
      end
      DREQ, IREQ: begin
        if (mem_ready) begin
          finishOk  = 1'b1;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          finishTimeout = 1'b1;
          stateNext     = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      iDone      <= 1'b0;
      dDone      <= 1'b0;
    end else begin
      if (advance) begin
        iDone <= 1'b0;
        dDone <= 1'b0;
      end

      if (issueData) begin
        mem_req   <= 1'b1;
        mem_wen   <= data_wen;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else if (issueInst) begin
        mem_req  <= 1'b1;
        mem_wen  <= '0;
        mem_addr <= inst_addr;
      end

      // A finishing port whose request is still high keeps cpu_stall high,
      // so advance cannot be clearing the same flag on this edge.
      if (finishOk || finishTimeout) begin
        mem_req <= 1'b0;
        if (state == DREQ) begin
          if (finishTimeout) begin
            data_rdata <= '0;
          end else if (mem_wen == 4'b0000) begin
            data_rdata <= mem_rdata;
          end
          if (data_req) begin
            dDone <= 1'b1;
          end
        end else begin
          inst_rdata <= finishTimeout ? 32'h0 : mem_rdata;
          if (inst_req) begin
            iDone <= 1'b1;
          end
        end
      end
    end
  end

endmodule
